// File: rtl/fnd_display_scheduler.sv
// Time-shares the 4-digit FND between the watch datapath and the DHT11 result,
// with a timed error screen that pre-empts both when the sensor reports a failure.
module fnd_display_scheduler #(
    parameter int CLK_PER_MS = 100000,
    parameter int ROTATE_MS  = 3000,
    parameter int ERR_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       auto_en,
    input  logic [7:0] w_msec,
    input  logic [7:0] w_sec,
    input  logic [7:0] w_min,
    input  logic [7:0] w_hour,
    input  logic       w_sw,
    input  logic [7:0] dht_hum,
    input  logic [7:0] dht_temp,
    input  logic       dht_valid,
    input  logic       dht_err,
    output logic [7:0] msec,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       sw,
    output logic [1:0] mode
);

    localparam int TW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int DW = (ROTATE_MS  > 1) ? $clog2(ROTATE_MS)  : 1;
    localparam int EW = (ERR_MS     > 1) ? $clog2(ERR_MS)     : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_PER_MS - 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(ROTATE_MS - 1);
    localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_MS - 1);

    typedef enum logic [1:0] {
        ST_WATCH = 2'b00,
        ST_DHT   = 2'b01,
        ST_ERR   = 2'b10
    } state_t;

    state_t          state;
    state_t          ret_state;
    state_t          other_state;
    logic [TW-1:0]   tick_cnt;
    logic [DW-1:0]   dwell;
    logic [EW-1:0]   err_timer;
    logic [7:0]      hum;
    logic [7:0]      temp;
    logic            tick;

    always_comb begin
        tick        = (tick_cnt == TICK_LAST);
        other_state = (state == ST_WATCH) ? ST_DHT : ST_WATCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WATCH;
            ret_state <= ST_WATCH;
            tick_cnt  <= '0;
            dwell     <= '0;
            err_timer <= '0;
            hum       <= '0;
            temp      <= '0;
            msec      <= '0;
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            sw        <= 1'b0;
            mode      <= ST_WATCH;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (dht_valid && !dht_err) begin
                hum  <= (dht_hum  > 8'd99) ? 8'd99 : dht_hum;
                temp <= (dht_temp > 8'd99) ? 8'd99 : dht_temp;
            end

            // Outputs follow the pre-update state so the display lags by one clk.
            mode <= state;
            unique case (state)
                ST_DHT: begin
                    sec  <= hum;
                    msec <= temp;
                    min  <= '0;
                    hour <= '0;
                    sw   <= 1'b0;
                end
                ST_ERR: begin
                    sec  <= 8'd99;
                    msec <= 8'd99;
                    min  <= 8'd99;
                    hour <= 8'd99;
                    sw   <= 1'b0;
                end
                default: begin
                    sec  <= w_sec;
                    msec <= w_msec;
                    min  <= w_min;
                    hour <= w_hour;
                    sw   <= w_sw;
                end
            endcase

            if (dht_err) begin
                if (state != ST_ERR)
                    ret_state <= state;
                state     <= ST_ERR;
                err_timer <= '0;
                dwell     <= '0;
            end else if (state == ST_ERR) begin
                if (tick) begin
                    if (err_timer == ERR_LAST) begin
                        state     <= ret_state;
                        dwell     <= '0;
                        err_timer <= '0;
                    end else begin
                        err_timer <= err_timer + 1'b1;
                    end
                end
            end else if (btn_mode) begin
                state <= other_state;
                dwell <= '0;
            end else if (auto_en && tick) begin
                if (dwell == DWELL_LAST) begin
                    state <= other_state;
                    dwell <= '0;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Scoreboard bench: a tick-count reference model predicts each cycle's display,
// a monitor process compares the DUT output one clk later.
module tb_fnd_display_scheduler;

    localparam int C = 10;
    localparam int R = 5;
    localparam int E = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, auto_en = 1'b0, w_sw = 1'b0;
    logic [7:0] w_msec = 8'd34, w_sec = 8'd12, w_min = '0, w_hour = '0;
    logic [7:0] dht_hum = '0, dht_temp = '0;
    logic       dht_valid = 1'b0, dht_err = 1'b0;
    logic [7:0] msec, sec, min, hour;
    logic       sw;
    logic [1:0] mode;

    fnd_display_scheduler #(.CLK_PER_MS(C), .ROTATE_MS(R), .ERR_MS(E)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .auto_en(auto_en),
        .w_msec(w_msec), .w_sec(w_sec), .w_min(w_min), .w_hour(w_hour), .w_sw(w_sw),
        .dht_hum(dht_hum), .dht_temp(dht_temp), .dht_valid(dht_valid), .dht_err(dht_err),
        .msec(msec), .sec(sec), .min(min), .hour(hour), .sw(sw), .mode(mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    // Reference model: 0 = watch screen, 1 = sensor screen, 2 = error screen
    int m_screen, m_back, m_cycles, m_ticks_shown, m_ticks_err, m_hum, m_temp;

    task automatic model_reset();
        m_screen = 0; m_back = 0; m_cycles = 0;
        m_ticks_shown = 0; m_ticks_err = 0; m_hum = 0; m_temp = 0;
    endtask

    function automatic logic [34:0] pack(int md, logic s, int h, int mi, int se, int ms);
        return {md[1:0], s, h[7:0], mi[7:0], se[7:0], ms[7:0]};
    endfunction

    task automatic check(string name, logic [34:0] act, logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act mode=%0d sw=%0d h=%0d m=%0d s=%0d ms=%0d exp mode=%0d sw=%0d h=%0d m=%0d s=%0d ms=%0d",
                     name, $time, act[34:33], act[32], act[31:24], act[23:16], act[15:8], act[7:0],
                     exp[34:33], exp[32], exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge and pushes the predicted display.
    task automatic step(logic b, logic a, logic v, logic e, logic [7:0] h, logic [7:0] t);
        bit tick;
        @(negedge clk);
        rst = 1'b0;
        btn_mode = b; auto_en = a; dht_valid = v; dht_err = e; dht_hum = h; dht_temp = t;
        if (m_cycles != 0) begin
            w_msec = 8'($urandom_range(0, 99)); w_sec = 8'($urandom_range(0, 59));
            w_min  = 8'($urandom_range(0, 59)); w_hour = 8'($urandom_range(0, 23));
            w_sw   = 1'($urandom_range(0, 1));
        end
        case (m_screen)
            0: exp_q.push_back(pack(0, w_sw, w_hour, w_min, w_sec, w_msec));
            1: exp_q.push_back(pack(1, 1'b0, 0, 0, m_hum, m_temp));
            default: exp_q.push_back(pack(2, 1'b0, 99, 99, 99, 99));
        endcase
        tick = ((m_cycles % C) == C - 1);
        m_cycles++;
        if (v && !e) begin
            m_hum  = (h > 99) ? 99 : int'(h);
            m_temp = (t > 99) ? 99 : int'(t);
        end
        if (e) begin
            if (m_screen != 2) m_back = m_screen;
            m_screen = 2; m_ticks_err = 0; m_ticks_shown = 0;
        end else if (m_screen == 2) begin
            if (tick) m_ticks_err++;
            if (m_ticks_err == E) begin m_screen = m_back; m_ticks_shown = 0; end
        end else if (b) begin
            m_screen = 1 - m_screen; m_ticks_shown = 0;
        end else if (a && tick) begin
            m_ticks_shown++;
            if (m_ticks_shown == R) begin m_screen = 1 - m_screen; m_ticks_shown = 0; end
        end
    endtask

    task automatic idle(int n, logic a);
        for (int i = 0; i < n; i++) step(1'b0, a, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin : monitor
        logic [34:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("display", {mode, sw, hour, min, sec, msec}, exp);
            end
        end
    end

    initial begin : stim
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {mode, sw, hour, min, sec, msec}, '0);

        idle(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd45, 8'd120);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        idle(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        idle(120, 1'b1);
        idle(13, 1'b1);
        idle(40, 1'b0);
        idle(60, 1'b1);

        if (m_screen != 1) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        idle(4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        idle(35, 1'b1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        idle(20, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        idle(40, 1'b0);

        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd77, 8'd66);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        idle(5, 1'b0);

        // Asynchronous reset during the error screen.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_err", {mode, sw, hour, min, sec, msec}, '0);
        model_reset();
        w_sec = 8'd12; w_msec = 8'd34; w_sw = 1'b0;
        @(negedge clk);
        idle(4, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0,
                 8'($urandom), 8'($urandom));
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
